mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mult_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Shares one 8x8 unsigned Wallace-tree multiplier between two requesters.
// Round-robin arbitration picks one requester, and only one transaction is
// in flight at a time.
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   req0_valid_i    requester 0 has operands
//   req0_ready_o    requester 0 operands accepted this cycle (with valid)
//   req0_a_i/_b_i   requester 0 operands, 8-bit unsigned
//   req1_*          same for requester 1
//   rsp_valid_o     result available
//   rsp_ready_i     consumer takes result
//   rsp_id_o        requester index owning the result
//   rsp_product_o   16-bit unsigned product
//
// Configuration
//   MULT_ARBITER_FAST_EN  defined: no CALC state. The multiplier is fed
//                         straight from the granted requester, and the
//                         product is captured on the accept edge (latency 1).
//                         undefined: IDLE -> CALC -> RESP (latency 2).
// -----------------------------------------------------------------------------

// 8x8 unsigned multiplier: eight partial-product rows reduced by a tree of
// carry-save adders down to two rows, then one carry-propagate add.
module mult_arbiter_wallace8 (
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   output logic [15:0] p_o
);
   logic [15:0] pp [8];
   logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

   function automatic logic [15:0] csa_sum(input logic [15:0] x, y, z);
      return x ^ y ^ z;
   endfunction

   function automatic logic [15:0] csa_carry(input logic [15:0] x, y, z);
      return ((x & y) | (x & z) | (y & z)) << 1;
   endfunction

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         pp[i] = b_i[i] ? ({8'd0, a_i} << i) : 16'd0;
      end
      // 8 rows -> 6 rows
      s0 = csa_sum(pp[0], pp[1], pp[2]);
      c0 = csa_carry(pp[0], pp[1], pp[2]);
      s1 = csa_sum(pp[3], pp[4], pp[5]);
      c1 = csa_carry(pp[3], pp[4], pp[5]);
      // 6 rows -> 4 rows
      s2 = csa_sum(s0, c0, s1);
      c2 = csa_carry(s0, c0, s1);
      s3 = csa_sum(c1, pp[6], pp[7]);
      c3 = csa_carry(c1, pp[6], pp[7]);
      // 4 rows -> 3 rows -> 2 rows
      s4 = csa_sum(s2, c2, s3);
      c4 = csa_carry(s2, c2, s3);
      s5 = csa_sum(s4, c4, c3);
      c5 = csa_carry(s4, c4, c3);
      // The product fits in 16 bits, so carries dropped past bit 15 are zero.
      p_o = s5 + c5;
   end
endmodule

module mult_arbiter (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [7:0]  req0_a_i,
   input  logic [7:0]  req0_b_i,
   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [7:0]  req1_a_i,
   input  logic [7:0]  req1_b_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_id_o,
   output logic [15:0] rsp_product_o
);
`ifdef MULT_ARBITER_FAST_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_e;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_e;
`endif

   state_e      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic [7:0]  a_q, a_d, b_q, b_d;
   logic        op_id_q, op_id_d;
   logic        rsp_id_q, rsp_id_d;
   logic [15:0] prod_q, prod_d;

   logic        grant0, grant1, accept;
   logic [7:0]  sel_a, sel_b, mul_a, mul_b;
   logic [15:0] mul_p;

   // Arbitration. On a tie the requester not granted last wins.
   // last_grant_q = 1 means requester 1 was granted last.
   always_comb begin
      grant0       = req0_valid_i & (~req1_valid_i | last_grant_q);
      grant1       = req1_valid_i & (~req0_valid_i | ~last_grant_q);
      req0_ready_o = (state_q == IDLE) & grant0;
      req1_ready_o = (state_q == IDLE) & grant1;
      accept       = req0_ready_o | req1_ready_o;
      sel_a        = grant1 ? req1_a_i : req0_a_i;
      sel_b        = grant1 ? req1_b_i : req0_b_i;
`ifdef MULT_ARBITER_FAST_EN
      mul_a        = sel_a;
      mul_b        = sel_b;
`else
      mul_a        = a_q;
      mul_b        = b_q;
`endif
   end

   mult_arbiter_wallace8 u_mul (
      .a_i (mul_a),
      .b_i (mul_b),
      .p_o (mul_p)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      a_d          = a_q;
      b_d          = b_q;
      op_id_d      = op_id_q;
      rsp_id_d     = rsp_id_q;
      prod_d       = prod_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d          = sel_a;
               b_d          = sel_b;
               op_id_d      = grant1;
               last_grant_d = grant1;
`ifdef MULT_ARBITER_FAST_EN
               prod_d       = mul_p;
               rsp_id_d     = grant1;
               state_d      = RESP;
`else
               state_d      = CALC;
`endif
            end
         end
`ifndef MULT_ARBITER_FAST_EN
         CALC: begin
            // The result id is copied along with the product, so rsp_id_o
            // keeps its old value until the new result is ready.
            prod_d   = mul_p;
            rsp_id_d = op_id_q;
            state_d  = RESP;
         end
`endif
         RESP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         a_q          <= 8'd0;
         b_q          <= 8'd0;
         op_id_q      <= 1'b0;
         rsp_id_q     <= 1'b0;
         prod_q       <= 16'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_id_q      <= op_id_d;
         rsp_id_q     <= rsp_id_d;
         prod_q       <= prod_d;
      end
   end

   assign rsp_valid_o   = (state_q == RESP);
   assign rsp_id_o      = rsp_id_q;
   assign rsp_product_o = prod_q;
endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [7:0]  req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_id;
   logic [15:0] rsp_product;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mult_arbiter dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .req0_valid_i  (req0_valid),
      .req0_ready_o  (req0_ready),
      .req0_a_i      (req0_a),
      .req0_b_i      (req0_b),
      .req1_valid_i  (req1_valid),
      .req1_ready_o  (req1_ready),
      .req1_a_i      (req1_a),
      .req1_b_i      (req1_b),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_id_o      (rsp_id),
      .rsp_product_o (rsp_product)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      rst_ni     = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   // Waits (bounded) for a response, samples it, then completes the handshake.
   task automatic wait_rsp(output logic found, output logic id, output logic [15:0] prod);
      found = 1'b0;
      id    = 1'b0;
      prod  = 16'd0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (rsp_valid === 1'b1) begin
            found = 1'b1;
            id    = rsp_id;
            prod  = rsp_product;
         end else begin
            tick();
         end
      end
      if (found) begin
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      #2 rst_ni = 1'b0;
      #1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
      n_cmp++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_id got=%b exp=0", rsp_id); end
      n_cmp++; if (rsp_product !== 16'h0000) begin n_fail++; $display("FAIL reset_product got=%h exp=0000", rsp_product); end
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_max;
      req0_a = 8'hFF; req0_b = 8'hFF; req0_valid = 1'b1;
      #1;
      n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL max_ready0 got=%b exp=1", req0_ready); end
      n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL max_ready1 got=%b exp=0", req1_ready); end
      tick();
      n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL max_ready0_busy got=%b exp=0", req0_ready); end
      req0_valid = 1'b0;
`ifndef MULT_ARBITER_FAST_EN
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL max_calc_valid got=%b exp=0", rsp_valid); end
      tick();
`endif
      n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL max_latency_valid got=%b exp=1", rsp_valid); end
      n_cmp++; if (rsp_product !== 16'hFE01) begin n_fail++; $display("FAIL max_product got=%h exp=fe01", rsp_product); end
      n_cmp++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL max_id got=%b exp=0", rsp_id); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL max_after_valid got=%b exp=0", rsp_valid); end
      n_cmp++; if (rsp_product !== 16'hFE01) begin n_fail++; $display("FAIL max_hold_product got=%h exp=fe01", rsp_product); end
   endtask

   task automatic test_tie;
      logic f, id;
      logic [15:0] p;
      do_reset();
      req0_a = 8'd12; req0_b = 8'd10; req1_a = 8'd7; req1_b = 8'd9;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL tie_first_grant got=%b%b exp=10", req0_ready, req1_ready); end
      wait_rsp(f, id, p);
      n_cmp++; if (f !== 1'b1 || id !== 1'b0 || p !== 16'h0078) begin n_fail++; $display("FAIL tie_rsp0 got=f%b id%b %h exp=f1 id0 0078", f, id, p); end
      wait_rsp(f, id, p);
      n_cmp++; if (f !== 1'b1 || id !== 1'b1 || p !== 16'h003F) begin n_fail++; $display("FAIL tie_rsp1 got=f%b id%b %h exp=f1 id1 003f", f, id, p); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_alternate;
      logic f, id, exp_id;
      logic [15:0] p, exp_p;
      do_reset();
      req0_a = 8'd3; req0_b = 8'd5; req1_a = 8'd4; req1_b = 8'd6;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_id = (k % 2 == 1);
         exp_p  = exp_id ? 16'd24 : 16'd15;
         wait_rsp(f, id, p);
         n_cmp++; if (f !== 1'b1 || id !== exp_id || p !== exp_p) begin n_fail++; $display("FAIL alt_txn%0d got=f%b id%b %h exp=f1 id%b %h", k, f, id, p, exp_id, exp_p); end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_stall;
      req1_a = 8'h80; req1_b = 8'h02; req1_valid = 1'b1;
      #1;
      n_cmp++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL stall_grant got=%b%b exp=01", req0_ready, req1_ready); end
      tick();
      req0_valid = 1'b1;
      #1;
`ifndef MULT_ARBITER_FAST_EN
      n_cmp++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL stall_calc got=v%b r%b%b exp=v0 r00", rsp_valid, req0_ready, req1_ready); end
      tick();
`endif
      for (int c = 0; c < 5; c++) begin
         n_cmp++; if (rsp_valid !== 1'b1 || rsp_product !== 16'h0100 || rsp_id !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d got=v%b id%b %h exp=v1 id1 0100", c, rsp_valid, rsp_id, rsp_product); end
         n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d got=%b%b exp=00", c, req0_ready, req1_ready); end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got=%b exp=0", rsp_valid); end
   endtask

   task automatic test_reset_calc;
      req0_a = 8'd5; req0_b = 8'd5; req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_product !== 16'h0000) begin n_fail++; $display("FAIL rstcalc_now got=v%b id%b %h exp=v0 id0 0000", rsp_valid, rsp_id, rsp_product); end
      tick();
      rst_ni = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstcalc_after%0d got=%b exp=0", c, rsp_valid); end
      end
   endtask

   task automatic test_operand_edges;
      logic f, id;
      logic [15:0] p;
      req0_a = 8'h00; req0_b = 8'hAB; req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      wait_rsp(f, id, p);
      n_cmp++; if (f !== 1'b1 || id !== 1'b0 || p !== 16'h0000) begin n_fail++; $display("FAIL edge_zero got=f%b id%b %h exp=f1 id0 0000", f, id, p); end
      req1_a = 8'h01; req1_b = 8'h01; req1_valid = 1'b1;
      tick();
      req1_valid = 1'b0;
      wait_rsp(f, id, p);
      n_cmp++; if (f !== 1'b1 || id !== 1'b1 || p !== 16'h0001) begin n_fail++; $display("FAIL edge_one got=f%b id%b %h exp=f1 id1 0001", f, id, p); end
   endtask

   initial begin
      test_reset();
      test_max();
      test_tie();
      test_alternate();
      test_stall();
      test_reset_calc();
      test_operand_edges();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
